// File: rtl/minirisc_bus_arbiter.sv
// Two-master round-robin arbiter for the MiniRISC data-memory bus, with an
// optional hold limit and a grant-qualified slave-bus mux.
module minirisc_bus_arbiter #(
  parameter int unsigned MAX_HOLD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_bus_req,
  output logic       m0_bus_grant,
  input  logic [7:0] m0_addr,
  input  logic [7:0] m0_data,
  input  logic       m0_wr,
  input  logic       m0_rd,
  input  logic       m1_bus_req,
  output logic       m1_bus_grant,
  input  logic [7:0] m1_addr,
  input  logic [7:0] m1_data,
  input  logic       m1_wr,
  input  logic       m1_rd,
  output logic [7:0] s_addr,
  output logic       s_wr,
  output logic       s_rd,
  output logic [7:0] s_data,
  output logic       s_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam bit         HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     state, state_nx;
  logic       last, last_nx;
  logic [7:0] hold_cnt, hold_nx;
  logic       g0_q, g1_q;

  always_comb begin
    state_nx = state;
    last_nx  = last;
    hold_nx  = hold_cnt;
    case (state)
      IDLE: begin
        // On a tie the master that was not granted last wins.
        if (m0_bus_req && (!m1_bus_req || last)) state_nx = OWN0;
        else if (m1_bus_req)                     state_nx = OWN1;
      end
      OWN0: begin
        if (m0_bus_req && !(HOLD_EN && m1_bus_req && hold_cnt == HOLD_LAST)) begin
          if (m1_bus_req && hold_cnt != '1) hold_nx = hold_cnt + 8'd1;
        end else if (m1_bus_req) begin
          state_nx = OWN1;
        end else begin
          state_nx = IDLE;
        end
      end
      OWN1: begin
        if (m1_bus_req && !(HOLD_EN && m0_bus_req && hold_cnt == HOLD_LAST)) begin
          if (m0_bus_req && hold_cnt != '1) hold_nx = hold_cnt + 8'd1;
        end else if (m0_bus_req) begin
          state_nx = OWN0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Entry into an OWN state restarts the tenure; IDLE keeps the counter clear.
    if (state_nx == OWN0 && state != OWN0) begin
      last_nx = 1'b0;
      hold_nx = '0;
    end else if (state_nx == OWN1 && state != OWN1) begin
      last_nx = 1'b1;
      hold_nx = '0;
    end else if (state_nx == IDLE) begin
      hold_nx = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold_cnt <= '0;
      g0_q     <= 1'b0;
      g1_q     <= 1'b0;
    end else begin
      state    <= state_nx;
      last     <= last_nx;
      hold_cnt <= hold_nx;
      g0_q     <= (state_nx == OWN0);
      g1_q     <= (state_nx == OWN1);
    end
  end

  assign m0_bus_grant = g0_q;
  assign m1_bus_grant = g1_q;

  assign s_addr = ({8{g0_q}} & m0_addr) | ({8{g1_q}} & m1_addr);
  assign s_data = ({8{g0_q}} & m0_data) | ({8{g1_q}} & m1_data);
  assign s_wr   = (g0_q & m0_wr) | (g1_q & m1_wr);
  assign s_rd   = (g0_q & m0_rd) | (g1_q & m1_rd);
  assign s_busy = g0_q | g1_q;

endmodule

// File: tb/tb_minirisc_bus_arbiter.sv
// Directed bench for minirisc_bus_arbiter: one instance with MAX_HOLD=4, one
// with MAX_HOLD=0; expected grants are written per step and queued.
module tb_minirisc_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0 [2], req1 [2], wr0 [2], rd0 [2], wr1 [2], rd1 [2];
  logic [7:0] addr0 [2], data0 [2], addr1 [2], data1 [2];
  logic       g0 [2], g1 [2], swr [2], srd [2], busy [2];
  logic [7:0] saddr [2], sdata [2];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         inst;
    logic       g0;
    logic       g1;
    logic [7:0] addr;
    logic [7:0] data;
    logic       wr;
    logic       rd;
    string      tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  minirisc_bus_arbiter #(.MAX_HOLD(4)) u_h4 (
    .clk(clk), .rst(rst),
    .m0_bus_req(req0[0]), .m0_bus_grant(g0[0]), .m0_addr(addr0[0]), .m0_data(data0[0]),
    .m0_wr(wr0[0]), .m0_rd(rd0[0]),
    .m1_bus_req(req1[0]), .m1_bus_grant(g1[0]), .m1_addr(addr1[0]), .m1_data(data1[0]),
    .m1_wr(wr1[0]), .m1_rd(rd1[0]),
    .s_addr(saddr[0]), .s_wr(swr[0]), .s_rd(srd[0]), .s_data(sdata[0]), .s_busy(busy[0])
  );

  minirisc_bus_arbiter #(.MAX_HOLD(0)) u_h0 (
    .clk(clk), .rst(rst),
    .m0_bus_req(req0[1]), .m0_bus_grant(g0[1]), .m0_addr(addr0[1]), .m0_data(data0[1]),
    .m0_wr(wr0[1]), .m0_rd(rd0[1]),
    .m1_bus_req(req1[1]), .m1_bus_grant(g1[1]), .m1_addr(addr1[1]), .m1_data(data1[1]),
    .m1_wr(wr1[1]), .m1_rd(rd1[1]),
    .s_addr(saddr[1]), .s_wr(swr[1]), .s_rd(srd[1]), .s_data(sdata[1]), .s_busy(busy[1])
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests with fresh payloads; the expected grant state
  // after the sampling edge is supplied by the caller.
  task automatic step(input int i, input logic r0, input logic r1,
                      input logic e0, input logic e1, input string tag);
    exp_t e;
    req0[i]  = r0;
    req1[i]  = r1;
    addr0[i] = 8'($urandom);
    data0[i] = 8'($urandom);
    wr0[i]   = 1'($urandom);
    rd0[i]   = 1'($urandom);
    addr1[i] = 8'($urandom);
    data1[i] = 8'($urandom);
    wr1[i]   = 1'($urandom);
    rd1[i]   = 1'($urandom);
    e.inst = i;
    e.g0   = e0;
    e.g1   = e1;
    e.addr = (e0 ? addr0[i] : 8'h00) | (e1 ? addr1[i] : 8'h00);
    e.data = (e0 ? data0[i] : 8'h00) | (e1 ? data1[i] : 8'h00);
    e.wr   = (e0 & wr0[i]) | (e1 & wr1[i]);
    e.rd   = (e0 & rd0[i]) | (e1 & rd1[i]);
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".g0"},   8'(g0[e.inst]),   8'(e.g0));
    chk({e.tag, ".g1"},   8'(g1[e.inst]),   8'(e.g1));
    chk({e.tag, ".busy"}, 8'(busy[e.inst]), 8'(e.g0 | e.g1));
    chk({e.tag, ".addr"}, saddr[e.inst],    e.addr);
    chk({e.tag, ".data"}, sdata[e.inst],    e.data);
    chk({e.tag, ".wr"},   8'(swr[e.inst]),  8'(e.wr));
    chk({e.tag, ".rd"},   8'(srd[e.inst]),  8'(e.rd));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      req0[i] = 1'b1;  req1[i] = 1'b1;
      wr0[i] = 1'b1;   rd0[i] = 1'b1;   wr1[i] = 1'b1;  rd1[i] = 1'b1;
      addr0[i] = 8'h11; data0[i] = 8'h33; addr1[i] = 8'h22; data1[i] = 8'h44;
    end
    rst = 1'b0;

    // Reset held with both requests high.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst.g0",   8'(g0[i]),   8'h00);
      chk("rst.g1",   8'(g1[i]),   8'h00);
      chk("rst.addr", saddr[i],    8'h00);
      chk("rst.wr",   8'(swr[i]),  8'h00);
    end
    req0[1] = 1'b0;
    req1[1] = 1'b0;
    rst = 1'b1;
    step(0, 1, 1, 1, 0, "tie_first");
    step(0, 0, 0, 0, 0, "tie_release");

    // Single master 1.
    step(0, 0, 1, 0, 1, "single_grant");
    step(0, 0, 1, 0, 1, "single_hold");
    step(0, 0, 0, 0, 0, "single_drop");

    // Round robin: each owner drops for one cycle after three owned cycles.
    step(0, 1, 1, 1, 0, "rr0a");
    step(0, 1, 1, 1, 0, "rr0b");
    step(0, 1, 1, 1, 0, "rr0c");
    step(0, 0, 1, 0, 1, "rr1a");
    step(0, 1, 1, 0, 1, "rr1b");
    step(0, 1, 1, 0, 1, "rr1c");
    step(0, 1, 0, 1, 0, "rr0d");
    step(0, 1, 1, 1, 0, "rr0e");
    step(0, 1, 1, 1, 0, "rr0f");
    step(0, 0, 1, 0, 1, "rr1d");
    step(0, 0, 0, 0, 0, "rr_idle");

    // Hold limit 4: m0 revoked, then re-granted with no gap.
    step(0, 1, 0, 1, 0, "hl_m0");
    step(0, 1, 0, 1, 0, "hl_m0_alone1");
    step(0, 1, 0, 1, 0, "hl_m0_alone2");
    step(0, 1, 1, 1, 0, "hl_wait1");
    step(0, 1, 1, 1, 0, "hl_wait2");
    step(0, 1, 1, 1, 0, "hl_wait3");
    step(0, 1, 1, 0, 1, "hl_revoke0");
    step(0, 1, 1, 0, 1, "hl_m1_own");
    step(0, 1, 0, 1, 0, "hl_regrant0");
    step(0, 0, 0, 0, 0, "hl_idle");
    // Symmetric: m1 owner revoked in favour of m0.
    step(0, 0, 1, 0, 1, "hl_m1");
    step(0, 1, 1, 0, 1, "hl_w1");
    step(0, 1, 1, 0, 1, "hl_w2");
    step(0, 1, 1, 0, 1, "hl_w3");
    step(0, 1, 1, 1, 0, "hl_revoke1");
    step(0, 0, 0, 0, 0, "hl_idle2");

    // No hold limit: m0 keeps the bus indefinitely, counter saturates.
    step(1, 1, 0, 1, 0, "nl_m0");
    for (int k = 0; k < 300; k++) step(1, 1, 1, 1, 0, "nl_hold");
    chk("nl_hold_sat", u_h0.hold_cnt, 8'hFF);
    step(1, 0, 1, 0, 1, "nl_handover");
    step(1, 0, 0, 0, 0, "nl_idle");

    // Async reset while m1 owns the bus and is writing.
    step(0, 0, 1, 0, 1, "ar_own1");
    wr1[0] = 1'b1;
    #1;
    chk("ar_pre.wr", 8'(swr[0]), 8'h01);
    chk("ar_pre.g1", 8'(g1[0]),  8'h01);
    #2;
    rst = 1'b0;
    #1;
    chk("ar.g1",   8'(g1[0]),   8'h00);
    chk("ar.wr",   8'(swr[0]),  8'h00);
    chk("ar.addr", saddr[0],    8'h00);
    chk("ar.busy", 8'(busy[0]), 8'h00);
    #20;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
